// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input frame buffer: defaults, read-FSM states,
// frame tag type and the index bit-reversal helper.
package fft_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned N_DEF     = 9;
  localparam int unsigned TAGW_DEF  = 4;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LOAD,
    RD_BURST
  } rd_state_t;

  typedef logic [TAGW_DEF-1:0] tag_t;

  // Reverse the low n bits of v; upper bits return zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned n);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < n; i++) begin
      r[i] = v[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The address MSB selects the ping-pong bank.
module fft_dpram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer ahead of the pipelined FFT: gathers 2**N-sample frames and
// replays each one as a contiguous burst in natural or bit-reversed order.
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned N     = N_DEF,
  parameter int unsigned TAGW  = TAGW_DEF
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             din_en,
  input  logic [WIDTH-1:0] din,
  input  logic             bitrev,
  output logic             dout_en,
  output logic             dout_sof,
  output logic [N-1:0]     dout_cnt,
  output logic [WIDTH-1:0] dout_re,
  output logic [WIDTH-1:0] dout_im,
  output logic [TAGW-1:0]  dout_tag,
  output logic             ovf
);

  logic [N-1:0]     wptr;
  logic             wb;
  logic             hold;
  logic [1:0]       full;
  logic [TAGW-1:0]  tag_cnt;
  logic [TAGW-1:0]  bank_tag [2];

  rd_state_t        state;
  logic             rb;
  logic             rmode;
  logic [N-1:0]     rcnt;
  logic [TAGW-1:0]  rtag;
  logic             rd_v;
  logic [N-1:0]     rd_cnt;

  logic             wr_go;
  logic             wr_last;
  logic             rd_release;
  logic [1:0]       full_nxt;
  logic [N-1:0]     raddr_lo;
  logic [WIDTH-1:0] rdata;

  // rcnt wraps to 0 after the last address, so BURST with rcnt==0 is the release
  // cycle; it lines up with the last output beat and keeps a 2-cycle burst gap.
  always_comb begin
    wr_go      = din_en && !hold;
    wr_last    = wr_go && (&wptr);
    rd_release = (state == RD_BURST) && (rcnt == '0);
    full_nxt   = full;
    if (rd_release) full_nxt[rb] = 1'b0;
    if (wr_last)    full_nxt[wb] = 1'b1;
    raddr_lo   = rmode ? N'(fft_pkg::bitrev(32'(rcnt), N)) : rcnt;
  end

  fft_dpram #(
    .WIDTH (WIDTH),
    .AW    (N + 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_go),
    .waddr ({wb, wptr}),
    .wdata (din),
    .raddr ({rb, raddr_lo}),
    .rdata (rdata)
  );

  assign dout_im = '0;

  always_ff @(posedge clk) begin
    if (!areset) begin
      wptr        <= '0;
      wb          <= 1'b0;
      hold        <= 1'b0;
      full        <= '0;
      tag_cnt     <= '0;
      bank_tag[0] <= '0;
      bank_tag[1] <= '0;
      state       <= RD_IDLE;
      rb          <= 1'b0;
      rmode       <= 1'b0;
      rcnt        <= '0;
      rtag        <= '0;
      rd_v        <= 1'b0;
      rd_cnt      <= '0;
      dout_en     <= 1'b0;
      dout_sof    <= 1'b0;
      dout_cnt    <= '0;
      dout_re     <= '0;
      dout_tag    <= '0;
      ovf         <= 1'b0;
    end else begin
      full <= full_nxt;

      if (wr_go) begin
        wptr <= wptr + 1'b1;
        if (wr_last) begin
          bank_tag[wb] <= tag_cnt;
          tag_cnt      <= tag_cnt + 1'b1;
          wb           <= ~wb;
          hold         <= full_nxt[~wb];
        end
      end else if (hold) begin
        if (din_en) ovf <= 1'b1;
        hold <= full_nxt[wb];
      end

      case (state)
        RD_IDLE: begin
          if (full[rb]) begin
            rmode <= bitrev;
            rtag  <= bank_tag[rb];
            state <= RD_LOAD;
          end
        end
        RD_LOAD: begin
          rcnt  <= rcnt + 1'b1;
          state <= RD_BURST;
        end
        RD_BURST: begin
          if (rcnt == '0) begin
            rb    <= ~rb;
            state <= RD_IDLE;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: state <= RD_IDLE;
      endcase

      rd_v     <= (state == RD_LOAD) || ((state == RD_BURST) && (rcnt != '0));
      rd_cnt   <= rcnt;
      dout_en  <= rd_v;
      dout_sof <= rd_v && (rd_cnt == '0);
      if (rd_v) begin
        dout_cnt <= rd_cnt;
        dout_re  <= rdata;
        dout_tag <= rtag;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Randomized bench for fft_frame_buffer (N=3) against a frame-level reference model.
module tb_fft_frame_buffer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = 3;
  localparam int unsigned TAGW  = 4;
  localparam int unsigned FLEN  = 2**N;

  logic             clk = 1'b0;
  logic             areset = 1'b0;
  logic             din_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             bitrev = 1'b0;
  logic             dout_en;
  logic             dout_sof;
  logic [N-1:0]     dout_cnt;
  logic [WIDTH-1:0] dout_re;
  logic [WIDTH-1:0] dout_im;
  logic [TAGW-1:0]  dout_tag;
  logic             ovf;

  fft_frame_buffer #(
    .WIDTH (WIDTH),
    .N     (N),
    .TAGW  (TAGW)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .din_en   (din_en),
    .din      (din),
    .bitrev   (bitrev),
    .dout_en  (dout_en),
    .dout_sof (dout_sof),
    .dout_cnt (dout_cnt),
    .dout_re  (dout_re),
    .dout_im  (dout_im),
    .dout_tag (dout_tag),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] re;
    int               cnt;
    logic [TAGW-1:0]  tag;
  } beat_t;

  beat_t            exp_q[$];
  int               cap_q[$];
  logic [TAGW-1:0]  tag_model = '0;
  logic [WIDTH-1:0] fr [FLEN];
  int               mode = 0;
  bit               rst_applied = 1'b1;
  bit               seen = 1'b0;
  int               gap = 0;
  beat_t            e;

  function automatic int rev_idx(input int k);
    int r = 0;
    for (int i = 0; i < int'(N); i++)
      if (((k >> i) & 1) != 0) r = r | (1 << (int'(N) - 1 - i));
    return r;
  endfunction

  // A completed frame comes out in index order k, reading fr[rev(k)] when bit-reversed.
  task automatic push_frame(input bit br);
    beat_t b;
    for (int k = 0; k < int'(FLEN); k++) begin
      b.re  = fr[br ? rev_idx(k) : k];
      b.cnt = k;
      b.tag = tag_model;
      exp_q.push_back(b);
    end
    tag_model = tag_model + 1'b1;
  endtask

  always @(posedge clk) rst_applied <= !areset;

  always @(negedge clk) begin
    if (rst_applied) begin
      check("rst_no_en", dout_en, 0);
      seen = 1'b0;
      gap  = 0;
    end else if (dout_en) begin
      if (dout_sof && seen) check("burst_gap_ge2", gap >= 2, 1);
      check("im_zero", dout_im, 0);
      if (mode == 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("re", dout_re, e.re);
          check("cnt", dout_cnt, e.cnt);
          check("sof", dout_sof, e.cnt == 0);
          check("tag", dout_tag, e.tag);
        end
      end else begin
        cap_q.push_back(int'(dout_re));
        check("cap_cnt", dout_cnt, (cap_q.size() - 1) % FLEN);
        check("cap_sof", dout_sof, ((cap_q.size() - 1) % FLEN) == 0);
      end
      seen = 1'b1;
      gap  = 0;
    end else begin
      gap++;
    end
  end

  task automatic write_sample(input logic [WIDTH-1:0] v);
    @(negedge clk);
    din_en = 1'b1;
    din    = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_en = 1'b0;
    end
  endtask

  task automatic send_frame(input int gmax);
    for (int k = 0; k < int'(FLEN); k++) begin
      write_sample(fr[k]);
      if (gmax > 0) idle($urandom_range(0, gmax));
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    @(negedge clk);
    din_en = 1'b0;
    while ((exp_q.size() != 0 || dout_en) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", t < 200, 1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < int'(FLEN); k++) fr[k] = WIDTH'($urandom);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int t;
    int nb;
    bit dropped;
    bit br;

    // Reset with din_en toggling: nothing should be captured or emitted.
    areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      din_en = ~din_en;
      din    = WIDTH'($urandom);
    end
    @(negedge clk);
    check("rst_en", dout_en, 0);
    check("rst_sof", dout_sof, 0);
    check("rst_cnt", dout_cnt, 0);
    check("rst_re", dout_re, 0);
    check("rst_tag", dout_tag, 0);
    check("rst_ovf", ovf, 0);
    din_en = 1'b0;
    areset = 1'b1;
    idle(12);

    // Natural-order ramp, with first-beat latency.
    bitrev = 1'b0;
    for (int k = 0; k < int'(FLEN); k++) fr[k] = WIDTH'(k);
    push_frame(1'b0);
    for (int k = 0; k < int'(FLEN); k++) write_sample(fr[k]);
    @(posedge clk);
    @(negedge clk);
    din_en = 1'b0;
    lat = 0;
    while (!dout_en && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, 3);
    wait_drain();

    // Bit-reversed ramp: 0,4,2,6,1,5,3,7.
    bitrev = 1'b1;
    push_frame(1'b1);
    send_frame(0);
    wait_drain();

    // bitrev flipped after the burst has started must not affect it.
    fill_random();
    bitrev = 1'b1;
    push_frame(1'b1);
    send_frame(0);
    t = 0;
    @(negedge clk);
    din_en = 1'b0;
    while (!dout_sof && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("sof_seen", t < 50, 1);
    bitrev = 1'b0;
    wait_drain();

    // Back-to-back frame pairs with din_en every cycle.
    for (int p = 0; p < 2; p++) begin
      br = p[0];
      bitrev = br;
      fill_random(); push_frame(br); send_frame(0);
      fill_random(); push_frame(br); send_frame(0);
      wait_drain();
    end
    check("ovf_after_stream", ovf, 0);

    // Randomized pairs with random din_en gaps; tags wrap past 2**TAGW.
    for (int p = 0; p < 8; p++) begin
      br = 1'($urandom_range(0, 1));
      bitrev = br;
      fill_random(); push_frame(br); send_frame(2);
      fill_random(); push_frame(br); send_frame(2);
      wait_drain();
    end
    check("ovf_after_random", ovf, 0);

    // Overflow: continuous ramp outruns the reader; every burst must be a whole frame.
    mode = 1;
    cap_q.delete();
    bitrev = 1'b0;
    for (int i = 0; i < 32; i++) write_sample(WIDTH'(100 + i));
    idle(80);
    check("ovf_set", ovf, 1);
    check("ovf_whole_bursts", cap_q.size() % FLEN, 0);
    nb = cap_q.size() / FLEN;
    check("ovf_burst_count_ge2", nb >= 2, 1);
    if (cap_q.size() > 0) check("ovf_first", cap_q[0], 100);
    dropped = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 1; k < int'(FLEN); k++)
        check("ovf_contig", cap_q[b*FLEN + k], cap_q[b*FLEN] + k);
      if (b > 0) begin
        check("ovf_order", cap_q[b*FLEN] > cap_q[b*FLEN - 1], 1);
        if (cap_q[b*FLEN] != cap_q[b*FLEN - 1] + 1) dropped = 1'b1;
      end
    end
    check("ovf_drop_seen", dropped, 1);
    mode = 0;

    // Reset mid-burst, then a fresh frame replays with tag 0.
    @(negedge clk);
    areset = 1'b0;
    idle(3);
    areset = 1'b1;
    tag_model = '0;
    exp_q.delete();
    @(negedge clk);
    check("ovf_cleared", ovf, 0);
    fill_random();
    push_frame(1'b0);
    bitrev = 1'b0;
    send_frame(0);
    @(negedge clk);
    din_en = 1'b0;
    t = 0;
    while (!(dout_en && dout_cnt == 3) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("cnt3_seen", t < 50, 1);
    areset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_en", dout_en, 0);
    exp_q.delete();
    idle(2);
    areset = 1'b1;
    tag_model = '0;
    idle(10);
    fill_random();
    bitrev = 1'b1;
    push_frame(1'b1);
    send_frame(1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
